// File: rtl/line_buffer_arbiter.sv
// Ping-pong scanline scheduler between the PPU pixel producer and VGA scan-out.
// Two line banks live in an external simple dual-port RAM; the PPU fills one
// while the VGA side re-reads the other REPEAT times (vertical line doubling).
module line_buffer_arbiter #(
    parameter int         LINE_PIXELS = 256,
    parameter int         REPEAT      = 2,
    parameter logic [5:0] BLACK_IDX   = 6'h0F,
    localparam int        CW          = $clog2(LINE_PIXELS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ppu_pix_valid,
    input  logic [5:0]  ppu_pix_idx,
    output logic        ppu_pix_ready,
    input  logic        vga_frame_start,
    input  logic        vga_line_start,
    input  logic        vga_re,
    output logic [5:0]  vga_pix_idx,
    output logic        buf_we,
    output logic [CW:0] buf_waddr,
    output logic [5:0]  buf_wdata,
    output logic [CW:0] buf_raddr,
    input  logic [5:0]  buf_rdata,
    output logic        underrun
);

    localparam logic [CW-1:0] PIX_LAST = CW'(LINE_PIXELS - 1);
    localparam logic [1:0]    REP_LAST = 2'(REPEAT - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t   bank_reg [2];
    bank_state_t   bank_next [2];
    logic          wb_reg, wb_next;
    logic          rb_reg, rb_next;
    logic [CW-1:0] wcnt_reg, wcnt_next;
    logic [CW-1:0] rcnt_reg, rcnt_next;
    logic [1:0]    rep_cnt_reg, rep_cnt_next;
    logic          rd_active_reg, rd_active_next;
    logic          rd_blank_reg, rd_blank_next;
    logic          underrun_reg, underrun_next;
    logic          show_reg, show_next;
    logic          wr_fire;
    logic          rd_fire;

    // Write side is purely a function of the current bank state.
    assign ppu_pix_ready = (bank_reg[wb_reg] == EMPTY) || (bank_reg[wb_reg] == FILLING);
    assign wr_fire       = ppu_pix_valid && ppu_pix_ready;
    assign buf_we        = wr_fire;
    assign buf_waddr     = {wb_reg, wcnt_reg};
    assign buf_wdata     = ppu_pix_idx;
    assign buf_raddr     = {rb_reg, rcnt_reg};

    // A line start or frame start takes priority over a pixel read in the same cycle.
    assign rd_fire = vga_re && rd_active_reg && !vga_line_start && !vga_frame_start;

    // The RAM output register holds the pixel; only the pixel/black selection is
    // registered here so the total read latency stays at one cycle.
    assign vga_pix_idx = show_reg ? buf_rdata : BLACK_IDX;
    assign underrun    = underrun_reg;

    // Next-state logic: write side, then frame start, then line start / pixel read.
    always_comb begin
        bank_next[0]   = bank_reg[0];
        bank_next[1]   = bank_reg[1];
        wb_next        = wb_reg;
        rb_next        = rb_reg;
        wcnt_next      = wcnt_reg;
        rcnt_next      = rcnt_reg;
        rep_cnt_next   = rep_cnt_reg;
        rd_active_next = rd_active_reg;
        rd_blank_next  = rd_blank_reg;
        underrun_next  = underrun_reg;
        show_next      = 1'b0;

        // Writes only touch an EMPTY/FILLING bank, reads only a FULL/DRAINING one,
        // so both sides can update bank_next in the same cycle without conflict.
        if (wr_fire) begin
            if (wcnt_reg == PIX_LAST) begin
                bank_next[wb_reg] = FULL;
                wb_next           = ~wb_reg;
                wcnt_next         = '0;
            end else begin
                bank_next[wb_reg] = FILLING;
                wcnt_next         = wcnt_reg + CW'(1);
            end
        end

        if (vga_frame_start) begin
            if (rep_cnt_reg != '0 || bank_reg[rb_reg] == DRAINING) begin
                bank_next[rb_reg] = EMPTY;
                rb_next           = ~rb_reg;
                rep_cnt_next      = '0;
            end
            rd_active_next = 1'b0;
        end

        if (vga_line_start) begin
            rd_active_next = 1'b1;
            rcnt_next      = '0;
            rd_blank_next  = 1'b0;
            // Evaluated against the post-frame-start read pointer.
            if (rep_cnt_next == '0) begin
                if (bank_reg[rb_next] == FULL) begin
                    bank_next[rb_next] = DRAINING;
                end else begin
                    underrun_next = 1'b1;
                    rd_blank_next = 1'b1;
                end
            end
        end else if (rd_fire) begin
            show_next = !rd_blank_reg;
            rcnt_next = rcnt_reg + CW'(1);
            if (rcnt_reg == PIX_LAST) begin
                rd_active_next = 1'b0;
                if (!rd_blank_reg) begin
                    if (rep_cnt_reg == REP_LAST) begin
                        bank_next[rb_reg] = EMPTY;
                        rb_next           = ~rb_reg;
                        rep_cnt_next      = '0;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + 2'd1;
                    end
                end
            end
        end
    end

    // State registers with synchronous reset; partial lines are simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_reg[0]   <= EMPTY;
            bank_reg[1]   <= EMPTY;
            wb_reg        <= 1'b0;
            rb_reg        <= 1'b0;
            wcnt_reg      <= '0;
            rcnt_reg      <= '0;
            rep_cnt_reg   <= '0;
            rd_active_reg <= 1'b0;
            rd_blank_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            show_reg      <= 1'b0;
        end else begin
            bank_reg[0]   <= bank_next[0];
            bank_reg[1]   <= bank_next[1];
            wb_reg        <= wb_next;
            rb_reg        <= rb_next;
            wcnt_reg      <= wcnt_next;
            rcnt_reg      <= rcnt_next;
            rep_cnt_reg   <= rep_cnt_next;
            rd_active_reg <= rd_active_next;
            rd_blank_reg  <= rd_blank_next;
            underrun_reg  <= underrun_next;
            show_reg      <= show_next;
        end
    end

endmodule
